// File: rtl/time_field_counter_if.sv
// Control and display bundle between the button/switch front end, time_field_counter and the display encoder.
// The countdown signals (count_dn, expired) exist only when COUNTDOWN_EN is defined.
interface time_field_counter_if #(
  parameter int MS_W  = 10,
  parameter int S_W   = 6,
  parameter int MIN_W = 6,
  parameter int HR_W  = 5
);
  // There is no valid/ready handshake. run and field_sel are levels.
  // button_in and clear act on every rising edge on which they are high.
  // tick_out and rollover are high for exactly one cycle per event.
  logic             run;
  logic             clear;
  logic             button_in;
  logic [1:0]       button_type;
  logic [1:0]       field_sel;
  logic [MS_W-1:0]  ms_out;
  logic [S_W-1:0]   s_out;
  logic [MIN_W-1:0] min_out;
  logic [HR_W-1:0]  hr_out;
  logic             tick_out;
  logic             rollover;
`ifdef COUNTDOWN_EN
  logic             count_dn;
  logic             expired;

  modport master (output run, clear, button_in, button_type, field_sel, count_dn,
                  input ms_out, s_out, min_out, hr_out, tick_out, rollover, expired);
  modport slave  (input run, clear, button_in, button_type, field_sel, count_dn,
                  output ms_out, s_out, min_out, hr_out, tick_out, rollover, expired);
`else
  modport master (output run, clear, button_in, button_type, field_sel,
                  input ms_out, s_out, min_out, hr_out, tick_out, rollover);
  modport slave  (input run, clear, button_in, button_type, field_sel,
                  output ms_out, s_out, min_out, hr_out, tick_out, rollover);
`endif
endinterface

// File: rtl/time_field_counter.sv
// Cascaded ms/s/min/hr stopwatch fields with a tick prescaler and per-field adjust while stopped.
// Optional countdown mode (count_dn/expired) is enabled by defining COUNTDOWN_EN.
module time_field_counter #(
  parameter int TICK_DIV = 100000,
  parameter int MS_MOD   = 1000,
  parameter int S_MOD    = 60,
  parameter int MIN_MOD  = 60,
  parameter int HR_MOD   = 24,
  parameter int BIG_STEP = 10
) (
  input  logic                clk,
  input  logic                reset,
  time_field_counter_if.slave bus
);
  localparam int MS_W  = $clog2(MS_MOD);
  localparam int S_W   = $clog2(S_MOD);
  localparam int MIN_W = $clog2(MIN_MOD);
  localparam int HR_W  = $clog2(HR_MOD);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]  MS_MAX    = MS_W'(MS_MOD - 1);
  localparam logic [S_W-1:0]   S_MAX     = S_W'(S_MOD - 1);
  localparam logic [MIN_W-1:0] MIN_MAX   = MIN_W'(MIN_MOD - 1);
  localparam logic [HR_W-1:0]  HR_MAX    = HR_W'(HR_MOD - 1);

  logic [PW-1:0]    presc, presc_d;
  logic [MS_W-1:0]  ms, ms_d;
  logic [S_W-1:0]   s, s_d;
  logic [MIN_W-1:0] mn, mn_d;
  logic [HR_W-1:0]  hr, hr_d;
  logic             tick_q, tick_d, roll_q, roll_d;
  logic             tick, adj, go, down;
  logic [31:0]      step;

  // The sum is formed wide, so f + step cannot overflow before the modulus is subtracted.
  function automatic logic [31:0] wrap_add(logic [31:0] f, logic [31:0] st, logic [31:0] m);
    logic [31:0] sum;
    sum = f + st;
    return (sum >= m) ? sum - m : sum;
  endfunction

`ifdef COUNTDOWN_EN
  logic exp_q, exp_d;
  assign down = bus.count_dn;
`else
  assign down = 1'b0;
`endif

  always_comb begin
    presc_d = presc;
    ms_d    = ms;
    s_d     = s;
    mn_d    = mn;
    hr_d    = hr;
    tick_d  = 1'b0;
    roll_d  = 1'b0;
    tick    = bus.run && (presc == PRESC_MAX);
    adj     = !bus.run && bus.button_in &&
              (bus.button_type == 2'b01 || bus.button_type == 2'b10);
    step    = (bus.button_type == 2'b10) ? 32'(BIG_STEP) : 32'd1;
    // A countdown that has reached all-zero swallows further ticks.
    go      = tick && !(down && ms == '0 && s == '0 && mn == '0 && hr == '0);
    if (bus.run) presc_d = tick ? '0 : presc + PW'(1);
    if (bus.clear) begin
      presc_d = '0;
      ms_d    = '0;
      s_d     = '0;
      mn_d    = '0;
      hr_d    = '0;
    end else if (adj) begin
      case (bus.field_sel)
        2'b00:   ms_d = MS_W'(wrap_add(32'(ms), step, 32'(MS_MOD)));
        2'b01:   s_d  = S_W'(wrap_add(32'(s), step, 32'(S_MOD)));
        2'b10:   mn_d = MIN_W'(wrap_add(32'(mn), step, 32'(MIN_MOD)));
        default: hr_d = HR_W'(wrap_add(32'(hr), step, 32'(HR_MOD)));
      endcase
    end else if (go) begin
      tick_d = 1'b1;
      if (down) begin
        ms_d = (ms == '0) ? MS_MAX : ms - MS_W'(1);
        if (ms == '0) begin
          s_d = (s == '0) ? S_MAX : s - S_W'(1);
          if (s == '0) begin
            mn_d = (mn == '0) ? MIN_MAX : mn - MIN_W'(1);
            if (mn == '0) hr_d = (hr == '0) ? HR_MAX : hr - HR_W'(1);
          end
        end
      end else begin
        ms_d = (ms == MS_MAX) ? '0 : ms + MS_W'(1);
        if (ms == MS_MAX) begin
          s_d = (s == S_MAX) ? '0 : s + S_W'(1);
          if (s == S_MAX) begin
            mn_d = (mn == MIN_MAX) ? '0 : mn + MIN_W'(1);
            if (mn == MIN_MAX) begin
              hr_d   = (hr == HR_MAX) ? '0 : hr + HR_W'(1);
              roll_d = (hr == HR_MAX);
            end
          end
        end
      end
    end
`ifdef COUNTDOWN_EN
    exp_d = down && !bus.clear && !adj &&
            ms_d == '0 && s_d == '0 && mn_d == '0 && hr_d == '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc  <= '0;
      ms     <= '0;
      s      <= '0;
      mn     <= '0;
      hr     <= '0;
      tick_q <= 1'b0;
      roll_q <= 1'b0;
    end else begin
      presc  <= presc_d;
      ms     <= ms_d;
      s      <= s_d;
      mn     <= mn_d;
      hr     <= hr_d;
      tick_q <= tick_d;
      roll_q <= roll_d;
    end
  end

`ifdef COUNTDOWN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exp_q <= 1'b0;
    else        exp_q <= exp_d;
  end
  assign bus.expired = exp_q;
`endif

  assign bus.ms_out   = ms;
  assign bus.s_out    = s;
  assign bus.min_out  = mn;
  assign bus.hr_out   = hr;
  assign bus.tick_out = tick_q;
  assign bus.rollover = roll_q;
endmodule

// File: tb/tb_time_field_counter.sv
// Bench for time_field_counter: elapsed-time reference model checked every cycle plus directed literal checks.
module tb_time_field_counter;
  localparam int TICK_DIV = 2;
  localparam int MS_MOD   = 10;
  localparam int S_MOD    = 6;
  localparam int MIN_MOD  = 6;
  localparam int HR_MOD   = 3;
  localparam int BIG_STEP = 4;
  localparam int TOTAL    = MS_MOD * S_MOD * MIN_MOD * HR_MOD;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   roll_cnt;
  int   roll_at;

  time_field_counter_if #(.MS_W(4), .S_W(3), .MIN_W(3), .HR_W(2)) bus ();

  time_field_counter #(
    .TICK_DIV(TICK_DIV), .MS_MOD(MS_MOD), .S_MOD(S_MOD),
    .MIN_MOD(MIN_MOD), .HR_MOD(HR_MOD), .BIG_STEP(BIG_STEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // model: the whole time value is one integer of elapsed ms, fields are digits of it
  int   m_t, m_presc, n_t, n_presc;
  logic m_tick, m_roll, m_exp, n_tick, n_roll, n_exp;
  logic n_tk, n_adj, dn;

`ifdef COUNTDOWN_EN
  assign dn = bus.count_dn;
`else
  assign dn = 1'b0;
`endif

  function automatic int f_ms(input int t);  return t % MS_MOD; endfunction
  function automatic int f_s(input int t);   return (t / MS_MOD) % S_MOD; endfunction
  function automatic int f_min(input int t); return (t / (MS_MOD * S_MOD)) % MIN_MOD; endfunction
  function automatic int f_hr(input int t);  return t / (MS_MOD * S_MOD * MIN_MOD); endfunction

  function automatic int adj_t(input int t, input int sel, input int st);
    int f[4];
    int mods[4];
    mods[0] = MS_MOD; mods[1] = S_MOD; mods[2] = MIN_MOD; mods[3] = HR_MOD;
    f[0] = f_ms(t); f[1] = f_s(t); f[2] = f_min(t); f[3] = f_hr(t);
    f[sel] = (f[sel] + st) % mods[sel];
    return ((f[3] * MIN_MOD + f[2]) * S_MOD + f[1]) * MS_MOD + f[0];
  endfunction

  always_comb begin
    n_tk    = bus.run && (m_presc == TICK_DIV - 1);
    n_adj   = !bus.run && bus.button_in && (bus.button_type == 2'b01 || bus.button_type == 2'b10);
    n_t     = m_t;
    n_presc = m_presc;
    n_tick  = 1'b0;
    n_roll  = 1'b0;
    if (bus.clear) begin
      n_t     = 0;
      n_presc = 0;
    end else begin
      if (bus.run) n_presc = n_tk ? 0 : m_presc + 1;
      if (n_adj) begin
        n_t = adj_t(m_t, int'(bus.field_sel), (bus.button_type == 2'b10) ? BIG_STEP : 1);
      end else if (n_tk && !(dn && m_t == 0)) begin
        n_tick = 1'b1;
        if (dn) n_t = m_t - 1;
        else begin
          n_roll = (m_t == TOTAL - 1);
          n_t    = (m_t + 1) % TOTAL;
        end
      end
    end
    n_exp = dn && (n_t == 0) && !bus.clear && !n_adj;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_t <= 0; m_presc <= 0; m_tick <= 1'b0; m_roll <= 1'b0; m_exp <= 1'b0;
    end else begin
      m_t <= n_t; m_presc <= n_presc; m_tick <= n_tick; m_roll <= n_roll; m_exp <= n_exp;
    end
  end

  // scoreboard compare on every falling edge while out of reset
  always @(negedge clk) begin
    if (reset) begin
      check("ms_model",   int'(bus.ms_out),   f_ms(m_t));
      check("s_model",    int'(bus.s_out),    f_s(m_t));
      check("min_model",  int'(bus.min_out),  f_min(m_t));
      check("hr_model",   int'(bus.hr_out),   f_hr(m_t));
      check("tick_model", int'(bus.tick_out), int'(m_tick));
      check("roll_model", int'(bus.rollover), int'(m_roll));
`ifdef COUNTDOWN_EN
      check("exp_model",  int'(bus.expired),  int'(m_exp));
`endif
    end
  end

  // driver tasks
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] sel, input logic [1:0] typ);
    bus.field_sel   = sel;
    bus.button_type = typ;
    bus.button_in   = 1'b1;
    @(negedge clk);
    bus.button_in   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ms"},   int'(bus.ms_out),   0);
    check({tag, "_s"},    int'(bus.s_out),    0);
    check({tag, "_min"},  int'(bus.min_out),  0);
    check({tag, "_hr"},   int'(bus.hr_out),   0);
    check({tag, "_tick"}, int'(bus.tick_out), 0);
    check({tag, "_roll"}, int'(bus.rollover), 0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus.run = 1'b0;
    bus.clear = 1'b0;
    bus.button_in = 1'b0;
    bus.button_type = 2'b00;
    bus.field_sel = 2'b00;
`ifdef COUNTDOWN_EN
    bus.count_dn = 1'b0;
`endif
    clks(3);
    check_zero("reset");

    // reset mid-count is immediate; first tick lands two clocks after run
    reset = 1'b1;
    bus.run = 1'b1;
    clks(2);
    check("first_tick_ms", int'(bus.ms_out), 1);
    check("first_tick_pulse", int'(bus.tick_out), 1);
    clks(5);
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    bus.run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // full day: one rollover, on the last clock
    bus.run = 1'b1;
    roll_cnt = 0;
    roll_at = 0;
    for (int c = 1; c <= TICK_DIV * TOTAL; c++) begin
      @(negedge clk);
      if (bus.rollover) begin
        roll_cnt++;
        roll_at = c;
      end
      if (c == 20) check("ten_ticks_s", int'(bus.s_out), 1);
      if (c == 1200) begin
        check("600_ticks_hr", int'(bus.hr_out), 1);
        check("600_ticks_min", int'(bus.min_out), 4);
      end
    end
    bus.run = 1'b0;
    check("roll_count", roll_cnt, 1);
    check("roll_cycle", roll_at, TICK_DIV * TOTAL);
    check("day_ms", int'(bus.ms_out), 0);
    check("day_hr", int'(bus.hr_out), 0);

    // adjust while stopped
    repeat (3) press(2'b01, 2'b01);
    press(2'b01, 2'b10);
    check("adj_s_wrap", int'(bus.s_out), 1);
    check("adj_no_carry_min", int'(bus.min_out), 0);
    check("adj_no_tick", int'(bus.tick_out), 0);
    press(2'b01, 2'b00);
    press(2'b01, 2'b11);
    check("adj_noop_types", int'(bus.s_out), 1);
    repeat (3) press(2'b00, 2'b10);
    check("adj_ms_big", int'(bus.ms_out), 2);
    repeat (2) press(2'b11, 2'b01);
    check("adj_hr_top", int'(bus.hr_out), 2);
    press(2'b11, 2'b01);
    check("adj_hr_wrap", int'(bus.hr_out), 0);
    check("adj_no_rollover", int'(bus.rollover), 0);
    repeat (2) press(2'b10, 2'b10);
    check("adj_min_big", int'(bus.min_out), 2);

    // buttons ignored while running; clear beats adjust
    bus.run = 1'b1;
    repeat (4) press(2'b00, 2'b01);
    check("run_ignores_button", int'(bus.ms_out), 4);
    check("run_keeps_s", int'(bus.s_out), 1);
    bus.run = 1'b0;
    bus.clear = 1'b1;
    bus.button_in = 1'b1;
    bus.button_type = 2'b01;
    bus.field_sel = 2'b00;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.button_in = 1'b0;
    check_zero("clear_vs_adjust");

    // pause keeps the prescaler phase
    bus.run = 1'b1;
    clks(2);
    check("after_clear_ms", int'(bus.ms_out), 1);
    clks(1);
    bus.run = 1'b0;
    clks(5);
    check("pause_no_tick", int'(bus.tick_out), 0);
    check("pause_ms", int'(bus.ms_out), 1);
    bus.run = 1'b1;
    clks(1);
    check("resume_tick", int'(bus.tick_out), 1);
    check("resume_ms", int'(bus.ms_out), 2);

    // clear on a tick cycle suppresses the tick and restarts the period
    clks(1);
    bus.clear = 1'b1;
    clks(1);
    bus.clear = 1'b0;
    check("clear_kills_tick", int'(bus.tick_out), 0);
    check("clear_ms", int'(bus.ms_out), 0);
    clks(2);
    check("clear_restart_ms", int'(bus.ms_out), 1);
    bus.run = 1'b0;

`ifdef COUNTDOWN_EN
    bus.count_dn = 1'b1;
    bus.clear = 1'b1;
    clks(1);
    bus.clear = 1'b0;
    clks(1);
    check("dn_expired_at_zero", int'(bus.expired), 1);
    press(2'b01, 2'b01);
    check("dn_load_s", int'(bus.s_out), 1);
    check("dn_adjust_clears_exp", int'(bus.expired), 0);
    bus.run = 1'b1;
    clks(2);
    check("dn_borrow_ms", int'(bus.ms_out), 9);
    check("dn_borrow_s", int'(bus.s_out), 0);
    clks(118);
    check("dn_end_ms", int'(bus.ms_out), 0);
    check("dn_end_expired", int'(bus.expired), 1);
    clks(4);
    check("dn_hold_ms", int'(bus.ms_out), 0);
    check("dn_hold_tick", int'(bus.tick_out), 0);
    check("dn_hold_expired", int'(bus.expired), 1);
    bus.count_dn = 1'b0;
    clks(1);
    check("dn_release_expired", int'(bus.expired), 0);
    bus.run = 1'b0;
    clks(2);
`endif

    clks(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
